// File: rtl/enhanced_processor.sv
// Multi-cycle bus processor: T0 fetch, T1 move/operand, T2 ALU, T3 writeback.
// All register, A/G and ALU transfers share one bus; R[] also has a combinational debug read port.
module enhanced_processor #(
    parameter int DATA_W = 9,
    parameter int NREGS  = 8,
    parameter int RSEL_W = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] DIN,
    input  logic [RSEL_W-1:0] dbg_sel,
    output logic              done,
    output logic [DATA_W-1:0] BusWire,
    output logic [DATA_W-1:0] IR,
    output logic [1:0]        tstep,
    output logic [DATA_W-1:0] G,
    output logic              zero,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    localparam logic [2:0] OP_MV   = 3'd0;
    localparam logic [2:0] OP_MVI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MVNZ = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;

    step_t             step_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] g_reg;
    logic              zero_reg;
    logic [DATA_W-1:0] r_reg [NREGS];

    logic [2:0]        opcode;
    logic [RSEL_W-1:0] x_sel;
    logic [RSEL_W-1:0] y_sel;
    logic [DATA_W-1:0] rx_val;
    logic [DATA_W-1:0] ry_val;
    logic [DATA_W-1:0] alu_next;
    logic [DATA_W-1:0] bus_val;
    logic              is_alu;
    logic              wr_en;

    assign opcode = ir_reg[DATA_W-1 -: 3];
    assign x_sel  = ir_reg[DATA_W-4 -: RSEL_W];
    assign y_sel  = ir_reg[DATA_W-4-RSEL_W -: RSEL_W];
    assign rx_val = r_reg[x_sel];
    assign ry_val = r_reg[y_sel];
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

    always_comb begin
        alu_next = '0;
        case (opcode)
            OP_ADD:  alu_next = a_reg + ry_val;
            OP_SUB:  alu_next = a_reg - ry_val;
            OP_AND:  alu_next = a_reg & ry_val;
            default: alu_next = '0;
        endcase
    end

    // Single shared bus: whatever is written anywhere this cycle comes from here.
    always_comb begin
        bus_val = DIN;
        case (step_reg)
            T1: begin
                if (opcode == OP_MV || opcode == OP_MVNZ)
                    bus_val = ry_val;
                else if (is_alu)
                    bus_val = rx_val;
                else
                    bus_val = DIN;
            end
            T2:      bus_val = alu_next;
            T3:      bus_val = g_reg;
            default: bus_val = DIN;
        endcase
    end

    assign done  = ((step_reg == T1) && !is_alu) || (step_reg == T3);
    assign wr_en = ((step_reg == T1) &&
                    ((opcode == OP_MV) || (opcode == OP_MVI) ||
                     ((opcode == OP_MVNZ) && !zero_reg))) ||
                   (step_reg == T3);

    // Reset wins over any write so an aborted instruction leaves no trace.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regfile
            always_ff @(posedge clock) begin
                if (!resetn)
                    r_reg[gi] <= '0;
                else if (wr_en && (x_sel == RSEL_W'(gi)))
                    r_reg[gi] <= bus_val;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!resetn) begin
            step_reg <= T0;
            ir_reg   <= '0;
            a_reg    <= '0;
            g_reg    <= '0;
            zero_reg <= 1'b1;
        end else begin
            case (step_reg)
                T0: begin
                    if (run) begin
                        ir_reg   <= DIN;
                        step_reg <= T1;
                    end
                end
                T1: begin
                    if (is_alu) begin
                        a_reg    <= bus_val;
                        step_reg <= T2;
                    end else begin
                        step_reg <= T0;
                    end
                end
                T2: begin
                    g_reg    <= alu_next;
                    zero_reg <= (alu_next == '0);
                    step_reg <= T3;
                end
                default: step_reg <= T0;
            endcase
        end
    end

    assign BusWire  = bus_val;
    assign IR       = ir_reg;
    assign tstep    = step_reg;
    assign G        = g_reg;
    assign zero     = zero_reg;
    assign dbg_data = r_reg[dbg_sel];

endmodule
